// File: rtl/fetch_queue_if.sv
// Bundle of fetch-side and decode-side signals around the instruction fetch queue.
// The master view belongs to the queue; the slave view belongs to the PC/memory/decode side.
interface fetch_queue_if;
  logic [31:0] PC_OUT;
  logic [31:0] MEM_DOUT1;
  logic        FLUSH;
  logic        ID_READY;
  logic        FETCH_EN;
  logic        ID_VALID;
  logic [31:0] ID_PC;
  logic [31:0] ID_PC_4;
  logic [31:0] ID_INSTR;

  modport master (
    input  PC_OUT, MEM_DOUT1, FLUSH, ID_READY,
    output FETCH_EN, ID_VALID, ID_PC, ID_PC_4, ID_INSTR
  );

  modport slave (
    output PC_OUT, MEM_DOUT1, FLUSH, ID_READY,
    input  FETCH_EN, ID_VALID, ID_PC, ID_PC_4, ID_INSTR
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch buffer: tags each fetch with its PC, captures the word a cycle later,
// queues {PC, PC+4, INSTR} for decode and throttles fetch by free credit.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic          CLK,
  input logic          RST,
  fetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] instr;
  } entry_t;

  entry_t           buffer [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             inflight_q;
  logic [31:0]      pc_d1;
  logic             fetch_en;
  logic             not_empty;
  logic             push;
  logic             pop;

  // In-flight fetches hold a credit, so the queue can never be pushed past DEPTH.
  always_comb begin
    not_empty = (count != '0);
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    fetch_en  = RST & (bus.FLUSH | (occupancy < DEPTH_OCC));
    push      = inflight_q & ~bus.FLUSH;
    pop       = not_empty & bus.ID_READY & ~bus.FLUSH;
    head      = buffer[rd_ptr];
  end

  always_comb begin
    bus.FETCH_EN = fetch_en;
    bus.ID_VALID = not_empty;
    bus.ID_PC    = '0;
    bus.ID_PC_4  = '0;
    bus.ID_INSTR = NOP_INSTR;
    if (not_empty) begin
      bus.ID_PC    = head.pc;
      bus.ID_PC_4  = head.pc_4;
      bus.ID_INSTR = head.instr;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inflight_q <= 1'b0;
      pc_d1      <= '0;
    end else begin
      if (fetch_en) begin
        pc_d1 <= bus.PC_OUT;
      end
      // A read issued during a redirect comes from the old PC and is dropped.
      inflight_q <= fetch_en & ~bus.FLUSH;
      if (bus.FLUSH) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      buffer[wr_ptr] <= {pc_d1, pc_d1 + 32'd4, bus.MEM_DOUT1};
    end
  end

  a_no_push_when_full : assert property (
    @(posedge CLK) disable iff (!RST) !(push && count == DEPTH_CNT)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: models the PC register and synchronous instruction memory
// (word = 0xA0000000 + address) and checks decode-side outputs against hand-derived values.
module tb_fetch_queue;

  localparam logic [31:0] REDIRECT = 32'h00000100;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] pc_reg;
  logic [31:0] mem_word;
  logic [31:0] pc_start = 32'h0;
  int          check_count = 0;
  int          error_count = 0;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(4), .NOP_INSTR(32'h00000013)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  always #5 CLK = ~CLK;

  assign bus.PC_OUT    = pc_reg;
  assign bus.MEM_DOUT1 = mem_word;

  // PC register and synchronous memory, both enabled by FETCH_EN.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_reg   <= pc_start;
      mem_word <= '0;
    end else if (bus.FETCH_EN) begin
      pc_reg   <= bus.FLUSH ? REDIRECT : pc_reg + 32'd4;
      mem_word <= 32'hA0000000 + pc_reg;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] pc_4, input logic [31:0] instr);
    checkOutput({tag, "_valid"}, {31'b0, bus.ID_VALID}, 32'd1);
    checkOutput({tag, "_pc"}, bus.ID_PC, pc);
    checkOutput({tag, "_pc4"}, bus.ID_PC_4, pc_4);
    checkOutput({tag, "_instr"}, bus.ID_INSTR, instr);
  endtask

  task automatic waitCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic flush, input logic ready);
    bus.FLUSH    = flush;
    bus.ID_READY = ready;
    #1;
  endtask

  // Leaves the bench in cycle 0 after reset release, inputs settled.
  task automatic startFromReset(input logic [31:0] start, input logic ready);
    RST          = 1'b0;
    pc_start     = start;
    bus.FLUSH    = 1'b0;
    bus.ID_READY = ready;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
  endtask

  logic [31:0] wrap_pc    [6] = '{32'hFFFFFFF0, 32'hFFFFFFF4, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
  logic [31:0] wrap_pc4   [6] = '{32'hFFFFFFF4, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004, 32'h00000008};
  logic [31:0] wrap_instr [6] = '{32'h9FFFFFF0, 32'h9FFFFFF4, 32'h9FFFFFF8, 32'h9FFFFFFC, 32'hA0000000, 32'hA0000004};

  initial begin
    bus.FLUSH    = 1'b0;
    bus.ID_READY = 1'b0;

    $display("[TB] reset with clock running");
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("rst_fetch_en", {31'b0, bus.FETCH_EN}, 32'd0);
    checkOutput("rst_valid", {31'b0, bus.ID_VALID}, 32'd0);
    checkOutput("rst_instr", bus.ID_INSTR, NOP);
    checkOutput("rst_pc", bus.ID_PC, 32'h0);
    checkOutput("rst_pc4", bus.ID_PC_4, 32'h0);

    $display("[TB] streaming");
    startFromReset(32'h0, 1'b1);
    checkOutput("stream_c0_fetch_en", {31'b0, bus.FETCH_EN}, 32'd1);
    checkOutput("stream_c0_valid", {31'b0, bus.ID_VALID}, 32'd0);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkOutput("stream_c1_valid", {31'b0, bus.ID_VALID}, 32'd0);
    for (int k = 2; k < 8; k++) begin
      waitCycle(); applyStimulus(1'b0, 1'b1);
      checkHead($sformatf("stream_c%0d", k), 32'(4 * (k - 2)), 32'(4 * (k - 2) + 4),
                32'hA0000000 + 32'(4 * (k - 2)));
    end

    $display("[TB] backpressure");
    startFromReset(32'h0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      waitCycle(); applyStimulus(1'b0, 1'b0);
      if (k == 4) checkOutput("bp_c4_fetch_en", {31'b0, bus.FETCH_EN}, 32'd0);
    end
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkOutput("bp_full_fetch_en", {31'b0, bus.FETCH_EN}, 32'd0);
    checkHead("bp_hold", 32'h0, 32'h4, 32'hA0000000);
    for (int j = 1; j < 6; j++) begin
      waitCycle(); applyStimulus(1'b0, 1'b1);
      checkHead($sformatf("bp_drain%0d", j), 32'(4 * j), 32'(4 * j + 4), 32'hA0000000 + 32'(4 * j));
    end

    $display("[TB] flush with three queued and one in flight");
    startFromReset(32'h0, 1'b0);
    repeat (4) begin
      waitCycle(); applyStimulus(1'b0, 1'b0);
    end
    checkOutput("fl_pre_fetch_en", {31'b0, bus.FETCH_EN}, 32'd0);
    checkHead("fl_pre", 32'h0, 32'h4, 32'hA0000000);
    applyStimulus(1'b1, 1'b1);
    checkOutput("fl_fetch_en", {31'b0, bus.FETCH_EN}, 32'd1);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkOutput("fl_p1_valid", {31'b0, bus.ID_VALID}, 32'd0);
    checkOutput("fl_p1_instr", bus.ID_INSTR, NOP);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkOutput("fl_p2_valid", {31'b0, bus.ID_VALID}, 32'd0);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkHead("fl_p3", 32'h00000100, 32'h00000104, 32'hA0000100);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkHead("fl_p4", 32'h00000104, 32'h00000108, 32'hA0000104);

    $display("[TB] address wrap");
    startFromReset(32'hFFFFFFF0, 1'b1);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      waitCycle(); applyStimulus(1'b0, 1'b1);
      checkHead($sformatf("wrap%0d", k), wrap_pc[k], wrap_pc4[k], wrap_instr[k]);
    end

    $display("[TB] async reset mid-stream");
    waitCycle();
    #2;
    pc_start = 32'h0;
    RST      = 1'b0;
    #1;
    checkOutput("arst_valid", {31'b0, bus.ID_VALID}, 32'd0);
    checkOutput("arst_fetch_en", {31'b0, bus.FETCH_EN}, 32'd0);
    checkOutput("arst_instr", bus.ID_INSTR, NOP);
    checkOutput("arst_pc", bus.ID_PC, 32'h0);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("arst_rel_fetch_en", {31'b0, bus.FETCH_EN}, 32'd1);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkOutput("arst_c1_valid", {31'b0, bus.ID_VALID}, 32'd0);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkHead("arst_c2", 32'h0, 32'h4, 32'hA0000000);
    waitCycle(); applyStimulus(1'b0, 1'b1);
    checkHead("arst_c3", 32'h4, 32'h8, 32'hA0000004);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
